// File: rtl/serializer_pkg.sv
// Shared definitions for the serial link blocks.
// Contents:
//   ser_state_t - shifter state (idle / shifting)
//   cnt_w()     - bit-counter width for a given word width
package serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Width of a counter that indexes every bit of a data_w-bit word.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register with a valid/ready write side.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   in_valid/in_data - upstream word and its valid
//   in_ready         - buffer empty and not in reset
//   pop              - consumer takes the held word this cycle
//   full, data       - held word and its occupancy flag
//
// Handshake: a word moves when in_valid && in_ready at a rising edge.
// in_ready never depends on in_valid. pop is only meaningful while full,
// and because in_ready is low while full, a write and a pop never land
// on the same edge.
module ser_hold_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push;

  assign in_ready = !full_q && !reset;
  assign push     = in_valid && in_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/serializer_nto1_stream.sv
// N-to-1 serializer: accepts DATA_W-bit words on a valid/ready bus and
// streams them one bit per clock, gap-free across back-to-back words.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - upstream handshake (word moves when both high)
//   in_data             - parallel word
//   ser_out             - serial bit (0 while idle)
//   ser_valid           - ser_out carries a data bit
//   ser_first/ser_last  - first / last bit of the current word
//   busy                - shifting or a word is waiting in the buffer
// Parameters:
//   DATA_W    - word width (2..256)
//   MSB_FIRST - 1: bit DATA_W-1 goes out first; 0: bit 0 goes out first
//
// All ser_* outputs and busy come from flops only. in_ready depends only
// on the holding-buffer flag and reset.
module serializer_nto1_stream
  import serializer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int               CNT_W    = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  ser_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              hold_pop;

  ser_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .pop      (hold_pop),
    .full     (hold_full),
    .data     (hold_data)
  );

  // Next-state logic. A load always takes the held word, so the buffer
  // is popped on exactly the edges where the shifter is (re)loaded.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    hold_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hold_full) begin
          state_d  = S_SHIFT;
          shift_d  = hold_data;
          cnt_d    = '0;
          hold_pop = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (hold_full) begin
            // Reload on the last bit so the next word follows with no gap.
            shift_d  = hold_data;
            cnt_d    = '0;
            hold_pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end
        end else begin
          if (MSB_FIRST) shift_d = shift_q << 1;
          else           shift_d = shift_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  logic out_bit;
  assign out_bit   = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
  assign ser_valid = (state_q == S_SHIFT);
  assign ser_out   = ser_valid && out_bit;
  assign ser_first = ser_valid && (cnt_q == '0);
  assign ser_last  = ser_valid && (cnt_q == CNT_LAST);
  assign busy      = ser_valid || hold_full;

endmodule

// File: tb/tb_serializer_nto1_stream.sv
// Directed bench for serializer_nto1_stream: an 8-bit MSB-first and an
// 8-bit LSB-first instance share one stimulus stream; a 32-bit default
// instance serializes a single reference word.
module tb_serializer_nto1_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       in_valid8;
  logic [7:0] in_data8;
  logic rdy_m, out_m, val_m, first_m, last_m, busy_m;
  logic rdy_l, out_l, val_l, first_l, last_l, busy_l;

  logic        in_valid32;
  logic [31:0] in_data32;
  logic rdy_w, out_w, val_w, first_w, last_w, busy_w;

  serializer_nto1_stream #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(rdy_m),
    .in_data(in_data8), .ser_out(out_m), .ser_valid(val_m),
    .ser_first(first_m), .ser_last(last_m), .busy(busy_m)
  );

  serializer_nto1_stream #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(rdy_l),
    .in_data(in_data8), .ser_out(out_l), .ser_valid(val_l),
    .ser_first(first_l), .ser_last(last_l), .busy(busy_l)
  );

  serializer_nto1_stream u_w32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(rdy_w),
    .in_data(in_data32), .ser_out(out_w), .ser_valid(val_w),
    .ser_first(first_w), .ser_last(last_w), .busy(busy_w)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  logic [7:0] drv_q[$];
  int         hs_q[$];

  // Presents each queued word with in_valid held high until accepted;
  // records the edge count of each handshake.
  task automatic drive8();
    bit ok;
    int b;
    while (drv_q.size() > 0) begin
      in_valid8 = 1'b1;
      in_data8  = drv_q[0];
      ok = 1'b0;
      b  = 0;
      while (!ok && b < 200) begin
        ok = rdy_m;
        tick();
        b++;
      end
      if (!ok) begin
        check("drive_timeout", 64'd0, 64'd1);
        break;
      end
      hs_q.push_back(cyc);
      void'(drv_q.pop_front());
    end
    in_valid8 = 1'b0;
    in_data8  = '0;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  // Reassembles words from both 8-bit instances and compares them with
  // exp_q; also checks framing and that the stream has no gaps.
  task automatic monitor8(input int budget);
    logic [7:0] acc_m, acc_l;
    int  nb = 0;
    int  gaps = 0;
    bit  started = 1'b0;
    int  b = 0;
    acc_m = '0;
    acc_l = '0;
    while (exp_q.size() > 0 && b < budget) begin
      tick();
      b++;
      if (val_m) begin
        started = 1'b1;
        check("first_m", first_m, nb == 0);
        check("last_m",  last_m,  nb == 7);
        check("valid_l", val_l, 1'b1);
        check("first_l", first_l, nb == 0);
        check("last_l",  last_l,  nb == 7);
        acc_m = {acc_m[6:0], out_m};
        acc_l = {out_l, acc_l[7:1]};
        if (nb == 7) begin
          check("word_m", acc_m, exp_q[0]);
          check("word_l", acc_l, exp_q[0]);
          void'(exp_q.pop_front());
          nb = 0;
        end else begin
          nb++;
        end
      end else if (started) begin
        gaps++;
      end
    end
    check("stream_done", exp_q.size(), 0);
    check("stream_gaps", gaps, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  pat_m, pat_l;
  logic [31:0] ref_w;

  initial begin
    reset      = 1'b1;
    in_valid8  = 1'b0;
    in_data8   = '0;
    in_valid32 = 1'b0;
    in_data32  = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready_m", rdy_m, 1'b0);
    check("rst_valid_m", val_m, 1'b0);
    check("rst_out_m",   out_m, 1'b0);
    check("rst_first_m", first_m, 1'b0);
    check("rst_last_m",  last_m, 1'b0);
    check("rst_busy_m",  busy_m, 1'b0);
    check("rst_valid_w", val_w, 1'b0);
    check("rst_busy_w",  busy_w, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_ready_m", rdy_m, 1'b1);
    check("post_rst_ready_w", rdy_w, 1'b1);

    // Single word 0x0F: MSB-first 0,0,0,0,1,1,1,1; LSB-first 1,1,1,1,0,0,0,0
    pat_m = 8'b0000_1111;
    pat_l = 8'b1111_0000;
    in_valid8 = 1'b1;
    in_data8  = 8'h0F;
    tick();
    in_valid8 = 1'b0;
    check("hs_ready_low", rdy_m, 1'b0);
    check("hs_busy",      busy_m, 1'b1);
    check("hs_no_valid",  val_m, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) check("load_ready_high", rdy_m, 1'b1);
      check("w0f_valid_m", val_m, 1'b1);
      check("w0f_bit_m",   out_m, pat_m[8-k]);
      check("w0f_bit_l",   out_l, pat_l[8-k]);
      check("w0f_first_m", first_m, k == 1);
      check("w0f_last_m",  last_m,  k == 8);
      check("w0f_first_l", first_l, k == 1);
      check("w0f_last_l",  last_l,  k == 8);
    end
    tick();
    check("w0f_c9_valid_m", val_m, 1'b0);
    check("w0f_c9_valid_l", val_l, 1'b0);
    check("w0f_c9_out_m",   out_m, 1'b0);
    check("w0f_c9_busy_m",  busy_m, 1'b0);

    // Back-to-back 0xA5, 0x3C, 0xFF: 24 contiguous bits
    drv_q = '{8'hA5, 8'h3C, 8'hFF};
    exp_q = '{8'hA5, 8'h3C, 8'hFF};
    hs_q.delete();
    fork
      drive8();
      monitor8(60);
    join
    check("b2b_hs_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("b2b_hs1_gap", hs_q[1] - hs_q[0], 2);
      check("b2b_hs2_gap", hs_q[2] - hs_q[0], 10);
    end
    tick();
    check("b2b_idle_valid", val_m, 1'b0);

    // Backpressure: third word stalls until the first reload
    drv_q = '{8'h11, 8'h22, 8'h33};
    exp_q = '{8'h11, 8'h22, 8'h33};
    hs_q.delete();
    fork
      drive8();
      monitor8(60);
    join
    check("bp_hs_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("bp_hs2_gap", hs_q[2] - hs_q[0], 10);
    end
    tick();

    // Reset mid-word: 0xC3 shifting, 0x5A held, reset during bit 4
    in_valid8 = 1'b1;
    in_data8  = 8'hC3;
    tick();                      // handshake C3
    in_data8  = 8'h5A;
    tick();                      // C3 loads, bit 1
    tick();                      // 5A accepted, bit 2
    in_valid8 = 1'b0;
    in_data8  = '0;
    check("mid_busy", busy_m, 1'b1);
    check("mid_ready_held", rdy_m, 1'b0);
    tick();                      // bit 3
    tick();                      // bit 4
    check("mid_valid_b4", val_m, 1'b1);
    reset = 1'b1;
    tick();
    check("rstmid_valid_m", val_m, 1'b0);
    check("rstmid_valid_l", val_l, 1'b0);
    check("rstmid_busy_m",  busy_m, 1'b0);
    check("rstmid_ready_m", rdy_m, 1'b0);
    reset = 1'b0;
    #1;
    check("rstmid_ready_after", rdy_m, 1'b1);
    tick();
    check("rstmid_no_resume", val_m, 1'b0);
    drv_q = '{8'h81};
    exp_q = '{8'h81};
    hs_q.delete();
    fork
      drive8();
      monitor8(30);
    join
    tick();
    check("w81_idle_busy", busy_m, 1'b0);

    // 32-bit default instance, 0xDEADBEEF MSB-first
    ref_w      = 32'hDEAD_BEEF;
    in_valid32 = 1'b1;
    in_data32  = ref_w;
    tick();
    in_valid32 = 1'b0;
    in_data32  = '0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("w32_valid", val_w, 1'b1);
      check("w32_bit",   out_w, ref_w[32-k]);
      check("w32_first", first_w, k == 1);
      check("w32_last",  last_w,  k == 32);
    end
    tick();
    check("w32_c33_valid", val_w, 1'b0);
    check("w32_c33_busy",  busy_w, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
